// File: rtl/seg_display_driver.sv
// Four-digit common-anode seven-segment scan driver with per-frame digit snapshot
// and adjust-mode blinking of one digit pair.
module seg_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk_used,
    input  logic       rst,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] digit4,
    input  logic       adj,
    input  logic       sel,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt_r;
    logic [1:0]    idx_r;
    logic [BW-1:0] blink_cnt_r;
    logic          blink_vis_r;
    logic [3:0]    snap1_r;
    logic [3:0]    snap2_r;
    logic [3:0]    snap3_r;
    logic [3:0]    snap4_r;
    logic [7:0]    seg_r;
    logic [3:0]    an_r;

    logic          refresh_wrap_s;
    logic          frame_end_s;
    logic          blink_wrap_s;
    logic [3:0]    cur_digit_s;
    logic [3:0]    an_next_s;
    logic          in_group_s;
    logic          blank_s;
    logic          dp_s;
    logic [7:0]    seg_next_s;

    // Active-low gfedcba pattern; non-BCD codes are dark rather than undefined.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Terminal-count strobes for the scan and blink dividers.
    always_comb begin
        refresh_wrap_s = (refresh_cnt_r == REFRESH_MAX);
        frame_end_s    = refresh_wrap_s && (idx_r == 2'd3);
        blink_wrap_s   = (blink_cnt_r == BLINK_MAX);
    end

    // Refresh divider and scan index.
    always_ff @(posedge clk_used) begin
        if (!rst) begin
            refresh_cnt_r <= {RW{1'b0}};
            idx_r         <= 2'd0;
        end else if (refresh_wrap_s) begin
            refresh_cnt_r <= {RW{1'b0}};
            idx_r         <= idx_r + 2'd1;
        end else begin
            refresh_cnt_r <= refresh_cnt_r + RW'(1);
        end
    end

    // Free-running blink divider, independent of the scan.
    always_ff @(posedge clk_used) begin
        if (!rst) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_vis_r <= 1'b1;
        end else if (blink_wrap_s) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_vis_r <= ~blink_vis_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1);
        end
    end

    // Digit snapshot, taken only at the frame boundary so a frame never tears.
    always_ff @(posedge clk_used) begin
        if (!rst) begin
            snap1_r <= 4'd0;
            snap2_r <= 4'd0;
            snap3_r <= 4'd0;
            snap4_r <= 4'd0;
        end else if (frame_end_s) begin
            snap1_r <= digit1;
            snap2_r <= digit2;
            snap3_r <= digit3;
            snap4_r <= digit4;
        end else begin
            snap1_r <= snap1_r;
            snap2_r <= snap2_r;
            snap3_r <= snap3_r;
            snap4_r <= snap4_r;
        end
    end

    // Digit and anode selection for the current scan slot.
    always_comb begin
        case (idx_r)
            2'd0: begin
                cur_digit_s = snap1_r;
                an_next_s   = 4'b0111;
            end
            2'd1: begin
                cur_digit_s = snap2_r;
                an_next_s   = 4'b1011;
            end
            2'd2: begin
                cur_digit_s = snap3_r;
                an_next_s   = 4'b1101;
            end
            2'd3: begin
                cur_digit_s = snap4_r;
                an_next_s   = 4'b1110;
            end
            default: begin
                cur_digit_s = 4'hF;
                an_next_s   = 4'b1111;
            end
        endcase
    end

    // Blanking and decimal point; adj/sel act live, group 0 is slots 0-1.
    always_comb begin
        if (sel) begin
            in_group_s = idx_r[1];
        end else begin
            in_group_s = ~idx_r[1];
        end
        blank_s = adj && !blink_vis_r && in_group_s;
        if ((idx_r == 2'd1) && !blank_s) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end
        if (blank_s) begin
            seg_next_s = 8'hFF;
        end else begin
            seg_next_s = {dp_s, bcd_to_seg(cur_digit_s)};
        end
    end

    // Registered display outputs; dark while in reset.
    always_ff @(posedge clk_used) begin
        if (!rst) begin
            seg_r <= 8'hFF;
            an_r  <= 4'b1111;
        end else begin
            seg_r <= seg_next_s;
            an_r  <= an_next_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;

endmodule
